// File: rtl/pipe_stage_buf.sv
// Parametrised pipeline buffer with valid/ready handshake, stall, flush and a saturating hold counter.
// Define PIPE_STAGE_SKID_EN to add a skid entry (full throughput, in_ready from registered state only).
module pipe_stage_buf #(
    parameter int unsigned DATA_W = 41,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              stall,
    input  logic              flush,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  hold_cnt,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state;
    logic [DATA_W-1:0] main_data;
    logic              main_valid;
    logic              xfer_in;
    logic              xfer_out;

    assign main_valid = (state != EMPTY);
    assign out_valid  = main_valid & ~stall & ~flush;
    assign out_data   = main_data;
    assign occupancy  = state;
    assign xfer_in    = in_valid & in_ready;
    assign xfer_out   = out_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic [DATA_W-1:0] skid_data;
    logic              skid_valid;

    // in_ready depends only on registered state: no out_ready -> in_ready path
    assign skid_valid = (state == TWO);
    assign in_ready   = ~skid_valid & ~stall & ~flush;
`else
    assign in_ready   = ~stall & ~flush & (~out_valid | out_ready);
`endif

    // Entry state, payload registers and hold counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            main_data <= '0;
`ifdef PIPE_STAGE_SKID_EN
            skid_data <= '0;
`endif
            hold_cnt  <= '0;
        end else begin
            if (cnt_clr) begin
                hold_cnt <= '0;
            end else if (main_valid && !xfer_out && hold_cnt != CNT_MAX) begin
                hold_cnt <= hold_cnt + CNT_W'(1);
            end

            if (flush) begin
                state     <= EMPTY;
                main_data <= '0;
`ifdef PIPE_STAGE_SKID_EN
                skid_data <= '0;
`endif
            end else if (!stall) begin
                case (state)
                    EMPTY: begin
                        if (xfer_in) begin
                            main_data <= in_data;
                            state     <= ONE;
                        end
                    end
                    ONE: begin
                        if (xfer_out && xfer_in) begin
                            main_data <= in_data;
                        end else if (xfer_out) begin
                            main_data <= '0;
                            state     <= EMPTY;
                        end
`ifdef PIPE_STAGE_SKID_EN
                        else if (xfer_in) begin
                            skid_data <= in_data;
                            state     <= TWO;
                        end
`endif
                    end
`ifdef PIPE_STAGE_SKID_EN
                    TWO: begin
                        // Skid is always younger than main, so it moves up on dequeue
                        if (xfer_out) begin
                            main_data <= skid_data;
                            skid_data <= '0;
                            state     <= ONE;
                        end
                    end
`endif
                    default: begin
                        main_data <= '0;
                        state     <= EMPTY;
                    end
                endcase
            end
        end
    end

endmodule
